// File: rtl/vending_ctrl.sv
// Drink vending controller: banks coins toward PRICE, dispenses one drink,
// then pays back change one ruble per cycle. Cancel refunds the banked credit.
module vending_ctrl #(
    parameter int PRICE     = 5,
    parameter int COIN_W    = 3,
    parameter int CREDIT_W  = 4,
    parameter int STOCK_MAX = 8,
    parameter int STOCK_W   = 4
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [COIN_W-1:0]   coin_value,
    input  logic                cancel,
    input  logic                restock,
    output logic                take_ur_drink,
    output logic                give_1_ruble_back,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock,
    output logic                busy,
    output logic                sold_out
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam logic [CREDIT_W:0]  PRICE_X    = (CREDIT_W+1)'(PRICE);
    localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_MAX);

    state_t              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [CREDIT_W-1:0] r_change, w_change_nxt;
    logic [STOCK_W-1:0]  r_stock, w_stock_nxt;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin;

    // One extra bit so credit+coin can never wrap before the PRICE compare.
    assign w_coin = (coin_value != '0);
    assign w_sum  = {1'b0, r_credit} + (CREDIT_W+1)'(coin_value);

    assign take_ur_drink     = (r_state == VEND);
    assign give_1_ruble_back = (r_state == CHANGE);
    assign busy              = (r_state == VEND) || (r_state == CHANGE);
    assign sold_out          = (r_stock == '0);
    assign coin_reject       = w_coin && (busy || (sold_out && !cancel));
    assign credit            = r_credit;
    assign stock             = r_stock;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_credit <= '0;
            r_change <= '0;
            r_stock  <= STOCK_FULL;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_change <= w_change_nxt;
            r_stock  <= w_stock_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_change_nxt = r_change;
        w_stock_nxt  = r_stock;
        case (r_state)
            IDLE, COLLECT: begin
                if (restock && (r_state == IDLE))
                    w_stock_nxt = STOCK_FULL;
                // A coin arriving with cancel is refunded, never banked.
                if (cancel) begin
                    if ((r_state == COLLECT) || w_coin) begin
                        w_change_nxt = w_sum[CREDIT_W-1:0];
                        w_credit_nxt = '0;
                        w_state_nxt  = CHANGE;
                    end
                end else if (w_coin && !sold_out) begin
                    if (w_sum < PRICE_X) begin
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                        w_state_nxt  = COLLECT;
                    end else begin
                        w_change_nxt = CREDIT_W'(w_sum - PRICE_X);
                        w_credit_nxt = '0;
                        w_state_nxt  = VEND;
                    end
                end
            end
            VEND: begin
                if (r_stock != '0)
                    w_stock_nxt = r_stock - 1'b1;
                w_state_nxt = (r_change != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                w_change_nxt = r_change - 1'b1;
                if (r_change <= CREDIT_W'(1))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/vending_ctrl.md
VENDING_CTRL -- requirements
Module: vending_ctrl

Interface
REQ-001 The block SHALL have parameter PRICE, default 5, the drink price in rubles (1..2**CREDIT_W-1).
REQ-002 The block SHALL have parameter COIN_W, default 3, the width of the coin value bus.
REQ-003 The block SHALL have parameter CREDIT_W, default 4, the width of the credit and change registers; CREDIT_W SHALL hold PRICE-1+2**COIN_W-1.
REQ-004 The block SHALL have parameter STOCK_MAX, default 8, the number of drinks loaded at reset and on restock.
REQ-005 The block SHALL have parameter STOCK_W, default 4, the width of the stock counter, which SHALL hold STOCK_MAX.
REQ-006 The block SHALL have port CLK  input  1  clock; all state updates occur on its rising edge.
REQ-007 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 The block SHALL have port coin_value  input  COIN_W  value in rubles of the coin presented this cycle; 0 means no coin.
REQ-009 The block SHALL have port cancel  input  1  request to refund the current credit.
REQ-010 The block SHALL have port restock  input  1  request to reload the stock to STOCK_MAX.
REQ-011 The block SHALL have port take_ur_drink  output  1  one-cycle drink-dispense pulse.
REQ-012 The block SHALL have port give_1_ruble_back  output  1  one ruble returned per asserted cycle.
REQ-013 The block SHALL have port coin_reject  output  1  the coin presented this cycle is not accepted (combinational).
REQ-014 The block SHALL have port credit  output  CREDIT_W  accumulated credit.
REQ-015 The block SHALL have port stock  output  STOCK_W  number of drinks remaining.
REQ-016 The block SHALL have port busy  output  1  asserted in VEND or CHANGE.
REQ-017 The block SHALL have port sold_out  output  1  asserted when stock==0.

Function
REQ-018 The FSM SHALL have exactly the states IDLE (credit==0), COLLECT (0<credit<PRICE), VEND and CHANGE.
REQ-019 In IDLE or COLLECT, a coin (coin_value!=0) with sold_out=0 and cancel=0 SHALL be accepted, forming sum = credit+coin_value computed at CREDIT_W+1 bits.
REQ-020 If sum<PRICE, credit SHALL become sum and the state SHALL become COLLECT.
REQ-021 If sum>=PRICE, the change register SHALL load sum-PRICE, credit SHALL clear to 0 and the state SHALL become VEND on the next edge.
REQ-022 VEND SHALL last exactly one cycle with take_ur_drink=1, and stock SHALL decrement by 1 at the end of that cycle.
REQ-023 From VEND the next state SHALL be CHANGE if change>0, else IDLE.
REQ-024 In CHANGE, give_1_ruble_back SHALL be 1 every cycle and change SHALL decrement by 1 per cycle; when change==1 the next state SHALL be IDLE, so exactly N pulses are issued for change N.
REQ-025 cancel in COLLECT SHALL load change with credit+coin_value (a coin in the same cycle is refunded, not banked), clear credit and enter CHANGE; take_ur_drink SHALL stay 0.
REQ-026 cancel in IDLE with no coin, or in VEND or CHANGE, SHALL be ignored.
REQ-027 cancel in IDLE with a coin present SHALL refund that coin through CHANGE.
REQ-028 coin_reject SHALL be 1 when coin_value!=0 and (busy=1, or sold_out=1 with cancel=0); a rejected coin SHALL NOT change credit or change.
REQ-029 restock SHALL set stock to STOCK_MAX only in IDLE; in other states it SHALL be ignored.
REQ-030 restock and a coin in the same IDLE cycle SHALL both take effect, with the coin evaluated against the pre-restock sold_out.
REQ-031 take_ur_drink and give_1_ruble_back SHALL be decoded from the registered state only, and SHALL never be asserted in the same cycle.
REQ-032 stock SHALL never wrap below 0; VEND SHALL be unreachable while sold_out=1.

Reset
REQ-033 When reset asserts, the block SHALL immediately, without waiting for CLK, force state=IDLE, credit=0, change=0, stock=STOCK_MAX, and take_ur_drink=give_1_ruble_back=busy=sold_out=0.
REQ-034 Reset mid-VEND or mid-CHANGE SHALL abandon any pending change with no further pulses.

Verification (defaults PRICE=5, STOCK_MAX=8)
REQ-035 Coins 2,2,1 on consecutive cycles -> credit 2,4, then one take_ur_drink cycle, stock 8->7, no give_1_ruble_back, back in IDLE.
REQ-036 Coins 3 then 5 -> one take_ur_drink cycle, then exactly 3 give_1_ruble_back cycles, then IDLE with credit 0.
REQ-037 Coin 2 then cancel -> exactly 2 give_1_ruble_back cycles, take_ur_drink never 1, stock unchanged.
REQ-038 Coin 1 during a CHANGE cycle -> coin_reject=1 that cycle, credit and remaining pulse count unchanged.
REQ-039 Eight vends of coin 5 -> stock 0, sold_out=1; then coin 5 -> coin_reject=1; then restock in IDLE -> stock 8, sold_out=0.
REQ-040 Assert reset during the 2nd of 3 change pulses -> give_1_ruble_back=0 at once, stock=8, credit=0, no further pulses after release.
